// File: rtl/wb_prog_port.sv
// Wishbone slave that lets a host hold a CPU in reset, load its instruction memory
// one byte per cycle, and read back a CPU-to-host mailbox byte.
module wb_prog_port #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  imem_addr,
    output logic [7:0]  imem_w_data,
    output logic        imem_w_en,
    output logic        cpu_reset,
    input  logic [7:0]  mbox_in
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_PTR    = 8'h08;
    localparam logic [7:0] OFF_DATA   = 8'h0C;
    localparam logic [7:0] OFF_MBOX   = 8'h10;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  slot;
    logic [1:0]  slot_nxt;
    logic [7:0]  imem_ptr;
    logic [31:0] rdata;

    logic        hit;
    logic [7:0]  offset;
    logic        imem_wr_req;
    logic        busy;
    logic [7:0]  lane_byte;
    logic [31:0] read_mux;

    assign offset      = wbs_adr_i[7:0];
    assign hit         = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign imem_wr_req = wbs_we_i & (offset == OFF_DATA);
    assign busy        = (state == BURST);

    always_comb begin
        read_mux = 32'h0;
        case (offset)
            OFF_CTRL:   read_mux = {31'b0, cpu_reset};
            OFF_STATUS: read_mux = {30'b0, cpu_reset, busy};
            OFF_PTR:    read_mux = {24'b0, imem_ptr};
            OFF_MBOX:   read_mux = {24'b0, mbox_in};
            default:    read_mux = 32'h0;
        endcase
    end

    always_comb begin
        lane_byte = 8'h0;
        case (slot)
            2'd0:    lane_byte = wbs_dat_i[7:0];
            2'd1:    lane_byte = wbs_dat_i[15:8];
            2'd2:    lane_byte = wbs_dat_i[23:16];
            default: lane_byte = wbs_dat_i[31:24];
        endcase
    end

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        case (state)
            IDLE: begin
                if (hit) begin
                    if (imem_wr_req && cpu_reset) begin
                        state_nxt = BURST;
                        slot_nxt  = 2'd0;
                    end else begin
                        state_nxt = ACK;
                    end
                end
            end
            BURST: begin
                // A master that drops the cycle abandons the rest of the word.
                if (!wbs_cyc_i) begin
                    state_nxt = IDLE;
                    slot_nxt  = 2'd0;
                end else if (slot == 2'd3) begin
                    state_nxt = ACK;
                    slot_nxt  = 2'd0;
                end else begin
                    slot_nxt = slot + 2'd1;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            slot      <= 2'd0;
            cpu_reset <= 1'b1;
            imem_ptr  <= 8'h0;
            rdata     <= 32'h0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
            if (state == IDLE && hit) begin
                rdata <= wbs_we_i ? 32'h0 : read_mux;
                // Register writes land on the accept edge so the new value is visible during ACK.
                if (wbs_we_i && wbs_sel_i[0]) begin
                    if (offset == OFF_CTRL) cpu_reset <= wbs_dat_i[0];
                    if (offset == OFF_PTR)  imem_ptr  <= wbs_dat_i[7:0];
                end
            end
            if (state == BURST && wbs_cyc_i && slot == 2'd3) begin
                imem_ptr <= imem_ptr + 8'd4;
            end
        end
    end

    assign wbs_ack_o   = (state == ACK);
    assign wbs_dat_o   = (state == ACK) ? rdata : 32'h0;
    assign imem_w_en   = busy & wbs_cyc_i & wbs_sel_i[slot];
    assign imem_addr   = busy ? (imem_ptr + {6'b0, slot}) : 8'h0;
    assign imem_w_data = busy ? lane_byte : 8'h0;

endmodule

// File: tb/tb_wb_prog_port.sv
// Scoreboard bench for wb_prog_port: stimulus pushes expected acks and imem writes,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_wb_prog_port;

    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ack;
    logic [31:0] rdat;
    logic [7:0]  iaddr;
    logic [7:0]  idata;
    logic        iwen;
    logic        cpu_reset;
    logic [7:0]  mbox;

    int n_cmp = 0;
    int n_err = 0;
    logic mon_en = 1'b0;
    logic cpu_reset_at_ack;

    logic [32:0] ack_q[$];
    logic [15:0] imem_q[$];

    wb_prog_port dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .imem_addr   (iaddr),
        .imem_w_data (idata),
        .imem_w_en   (iwen),
        .cpu_reset   (cpu_reset),
        .mbox_in     (mbox)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT acks or writes imem.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ack === 1'b1) begin
                if (ack_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_ack: got ack=1 expected none (t=%0t)", $time);
                end else begin
                    logic [32:0] e;
                    e = ack_q.pop_front();
                    if (e[32]) check("ack_data", rdat, e[31:0]);
                end
            end else if (rdat !== 32'h0) begin
                n_cmp++;
                n_err++;
                $display("FAIL dat_idle: got %h expected 00000000", rdat);
            end
            if (iwen === 1'b1) begin
                if (imem_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_imem: got addr=%h data=%h expected no write", iaddr, idata);
                end else begin
                    logic [15:0] w;
                    w = imem_q.pop_front();
                    check("imem_write", {16'h0, iaddr, idata}, {16'h0, w});
                end
            end
        end
    end

    task automatic idle_bus();
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        sel = 4'h0;
    endtask

    // exp_lat = 0 means no ack is expected within the budget.
    task automatic xfer(input string nm, input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input int exp_lat, input logic chk_dat,
                        input logic [31:0] exp_dat);
        int cnt;
        if (exp_lat > 0) ack_q.push_back({chk_dat, exp_dat});
        adr = a;
        we  = w;
        dat = d;
        sel = s;
        cyc = 1'b1;
        stb = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) begin
                cnt = i;
                cpu_reset_at_ack = cpu_reset;
                break;
            end
        end
        idle_bus();
        check({nm, "_lat"}, cnt, exp_lat);
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        xfer(nm, a, 1'b0, 32'h0, 4'hF, 1, 1'b1, exp);
    endtask

    task automatic wr(input string nm, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int lat);
        xfer(nm, a, 1'b1, d, s, lat, 1'b0, 32'h0);
    endtask

    initial begin
        logic acked;
        rst = 1'b1;
        mbox = 8'h00;
        adr = 32'h0;
        dat = 32'h0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        check("rst_wen", {31'b0, iwen}, 32'h0);
        check("rst_addr", {24'b0, iaddr}, 32'h0);
        check("rst_wdata", {24'b0, idata}, 32'h0);
        check("rst_cpu_reset", {31'b0, cpu_reset}, 32'h1);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        rd("status_rst", 32'h3000_0004, 32'h0000_0002);

        wr("ptr10", 32'h3000_0008, 32'h0000_0010, 4'h1, 1);
        imem_q.push_back({8'h10, 8'hAA});
        imem_q.push_back({8'h11, 8'hBB});
        imem_q.push_back({8'h12, 8'hCC});
        imem_q.push_back({8'h13, 8'hDD});
        wr("burst_full", 32'h3000_000C, 32'hDDCC_BBAA, 4'hF, 5);
        rd("ptr_14", 32'h3000_0008, 32'h0000_0014);

        wr("ptrFE", 32'h3000_0008, 32'h0000_00FE, 4'h1, 1);
        imem_q.push_back({8'hFE, 8'h11});
        imem_q.push_back({8'h00, 8'h33});
        wr("burst_wrap", 32'h3000_000C, 32'h4433_2211, 4'b0101, 5);
        rd("ptr_02", 32'h3000_0008, 32'h0000_0002);

        wr("ctrl0", 32'h3000_0000, 32'h0000_0000, 4'h1, 1);
        check("cpu_reset_at_ack", {31'b0, cpu_reset_at_ack}, 32'h0);
        wr("data_norst", 32'h3000_000C, 32'h5555_5555, 4'hF, 1);
        rd("ptr_keep", 32'h3000_0008, 32'h0000_0002);
        rd("status_run", 32'h3000_0004, 32'h0000_0000);

        wr("ctrl1", 32'h3000_0000, 32'h0000_0001, 4'h1, 1);
        imem_q.push_back({8'h02, 8'h21});
        adr = 32'h3000_000C;
        we  = 1'b1;
        dat = 32'h8765_4321;
        sel = 4'hF;
        cyc = 1'b1;
        stb = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        idle_bus();
        acked = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) acked = 1'b1;
        end
        check("drop_noack", {31'b0, acked}, 32'h0);
        rd("ptr_drop", 32'h3000_0008, 32'h0000_0002);
        imem_q.push_back({8'h05, 8'hAB});
        wr("burst_after", 32'h3000_000C, 32'hAB00_0000, 4'b1000, 5);
        rd("ptr_06", 32'h3000_0008, 32'h0000_0006);

        mbox = 8'h5A;
        rd("mbox", 32'h3000_0010, 32'h0000_005A);
        rd("unmapped", 32'h3000_0040, 32'h0000_0000);
        xfer("nomatch", 32'h3000_0100, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0);

        imem_q.push_back({8'h06, 8'h44});
        adr = 32'h3000_000C;
        we  = 1'b1;
        dat = 32'h1122_3344;
        sel = 4'hF;
        cyc = 1'b1;
        stb = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_burst_wen", {31'b0, iwen}, 32'h0);
        check("rst_burst_ack", {31'b0, ack}, 32'h0);
        idle_bus();
        @(posedge clk);
        #1;
        rd("ctrl_after_rst", 32'h3000_0000, 32'h0000_0001);
        rd("ptr_after_rst", 32'h3000_0008, 32'h0000_0000);

        repeat (2) @(posedge clk);
        #1;
        check("ack_q_empty", ack_q.size(), 32'h0);
        check("imem_q_empty", imem_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_prog_port.md
WB_PROG_PORT -- requirements
Module: wb_prog_port

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: wb_clk_i is the clock, wb_rst_i is the reset.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h3000_0000, giving the register-window base; only wbs_adr_i[31:8]==BASE_ADDR[31:8] decodes.
REQ-003 Port list:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte-lane select.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- imem_addr  out  8  instruction-memory write address.
- imem_w_data  out  8  instruction-memory write byte.
- imem_w_en  out  1  instruction-memory write strobe.
- cpu_reset  out  1  CPU hold-in-reset.
- mbox_in  in  8  CPU-to-host status byte.

Function
REQ-004 Register map, offset = wbs_adr_i[7:0]:
- 0x00 CTRL: R/W, bit0 = cpu_reset.
- 0x04 STATUS: RO, {30'b0, cpu_reset, busy}.
- 0x08 IMEM_PTR: R/W, 8 bits.
- 0x0C IMEM_DATA: WO, reads 0.
- 0x10 MBOX: RO, {24'b0, mbox_in}.
- All other offsets: read 0, writes ignored, still acked.
REQ-005 A request is accepted only in state IDLE, on a cycle with wbs_cyc_i & wbs_stb_i & address match; non-matching addresses are never acked.
REQ-006 FSM states:
- IDLE.
- BURST, with byte slot k = 0..3.
- ACK.
REQ-007 Transitions:
- Accepted non-IMEM_DATA request: IDLE -> ACK.
- Accepted IMEM_DATA write with cpu_reset=1: IDLE -> BURST(k=0).
- BURST(k) -> BURST(k+1) for k<3; BURST(3) -> ACK.
- ACK -> IDLE.
REQ-008 Latency: request accepted at cycle N.
- Register access: wbs_ack_o high at N+1 only.
- IMEM_DATA write: slots at N+1..N+4, wbs_ack_o high at N+5 only.
REQ-009 wbs_ack_o SHALL be high for exactly one cycle per accepted request; no request is accepted in the ACK cycle.
REQ-010 wbs_dat_o SHALL carry read data during the ACK cycle and 32'h0 in every other cycle.
REQ-011 Register writes SHALL update only on bytes with sel set, applied in the ACK cycle; CTRL and IMEM_PTR use lane 0 only.
REQ-012 In BURST slot k:
- imem_addr = IMEM_PTR + k, modulo 256.
- imem_w_data = wbs_dat_i[8k+7:8k].
- imem_w_en = wbs_sel_i[k].
- A slot with a deasserted lane is consumed with imem_w_en=0.
REQ-013 imem_w_en SHALL be 0 outside BURST; imem_addr and imem_w_data are 0 outside BURST.
REQ-014 IMEM_PTR SHALL increment by 4 (mod 256) in the ACK cycle of a completed burst; 0xFC wraps to 0x00.
REQ-015 An IMEM_DATA write with cpu_reset=0 SHALL be acked at N+1 with no imem_w_en pulse and no pointer change.
REQ-016 busy SHALL be 1 in BURST and 0 otherwise.
REQ-017 If wbs_cyc_i drops during BURST:
- Remaining slots are abandoned.
- Next state is IDLE, with no ack.
- IMEM_PTR is unchanged.
- Bytes already written remain written.
REQ-018 wbs_dat_i and wbs_sel_i SHALL be sampled every BURST cycle; the master holds them stable until ack.

Reset
REQ-019 While wb_rst_i=1 at a clock edge, the block SHALL take these values on that edge:
- state IDLE.
- cpu_reset=1.
- IMEM_PTR=0.
- wbs_ack_o=0, wbs_dat_o=0.
- imem_w_en=0, imem_addr=0, imem_w_data=0.
REQ-020 wb_rst_i mid-burst SHALL abort without ack; no imem_w_en in the cycle after the reset edge.

Verification
REQ-021 Bench SHALL cover these scenarios:
- Reset, then read STATUS -> ack 1 cycle after strobe; data 32'h0000_0002.
- Write IMEM_PTR=0x10; write IMEM_DATA=0xDDCCBBAA, sel=4'hF -> imem_w_en at N+1..N+4 with (0x10,AA),(0x11,BB),(0x12,CC),(0x13,DD); ack at N+5; IMEM_PTR reads 0x14.
- IMEM_PTR=0xFE, IMEM_DATA sel=4'b0101 -> writes (0xFE,lane0) and (0x00,lane2) only; IMEM_PTR reads 0x02.
- Write CTRL=0 -> cpu_reset falls in the ack cycle; then IMEM_DATA write -> ack at N+1, no imem_w_en, IMEM_PTR unchanged.
- wbs_cyc_i dropped at N+2 of a burst -> exactly one byte written, no ack, IMEM_PTR unchanged; next request behaves normally.
- mbox_in=0x5A, read 0x10 -> 0x0000_005A; read 0x40 -> 0 with ack; read 0x3000_0100 -> no ack.
